// File: rtl/fifo_drain_ctrl.sv
// FIFO read-side drain controller with a 2-entry output skid buffer.
// Optional FIFO_DRAIN_CNT_EN adds the drain_cnt delivered-word counter.
module fifo_drain_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]       drain_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t              occ_q, occ_d;
  logic              inflight;
  logic              run;
  logic              pop;
  logic [2:0]        lvl;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ_q != EMPTY);
  assign m_data  = head_q;

  // Pop-aware level lets reads continue at full rate.
  assign lvl = {1'b0, occ_q} + {2'b0, inflight} - {2'b0, pop};

  // run holds reads off until the first edge after reset release.
  assign fifo_r_en = run && drain_en && !fifo_empty
                  && (lvl < 3'(BUF_DEPTH));

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      (inflight && !pop): begin
        if (occ_q == EMPTY) begin
          head_d = fifo_data;
          occ_d  = ONE;
        end else if (occ_q == ONE) begin
          tail_d = fifo_data;
          occ_d  = TWO;
        end
      end
      (!inflight && pop): begin
        if (occ_q == TWO) begin
          head_d = tail_q;
          occ_d  = ONE;
        end else begin
          occ_d  = EMPTY;
        end
      end
      (inflight && pop): begin
        if (occ_q == TWO) begin
          head_d = tail_q;
          tail_d = fifo_data;
        end else begin
          head_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= EMPTY;
      inflight <= 1'b0;
      run      <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      occ_q    <= occ_d;
      inflight <= fifo_r_en && !fifo_empty;
      run      <= 1'b1;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= 16'd0;
    end else if (pop) begin
      drain_cnt <= drain_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed self-checking bench for fifo_drain_ctrl.
// Behavioural registered FIFO source plus a pop/occupancy monitor.
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drain_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_r_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] drain_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       inf_src = 1'b0;

  int         rd_cnt = 0;
  int         pop_total = 0;
  int         ovf_cnt = 0;
  int         m_occ = 0;
  logic       m_infl = 1'b0;
  logic [7:0] pops [$];

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.DATA_W(8), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drain_en   (drain_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .drain_cnt  (drain_cnt)
`endif
  );

  assign fifo_empty = !inf_src && (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) begin
      if (inf_src) begin
        fifo_data <= 8'h55;
      end else begin
        fifo_data <= mem[rd_ptr[3:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_occ  <= 0;
      m_infl <= 1'b0;
    end else begin
      if (m_infl && !(m_valid && m_ready) && m_occ == 2)
        ovf_cnt <= ovf_cnt + 1;
      m_occ  <= m_occ + (m_infl ? 1 : 0)
              - ((m_valid && m_ready) ? 1 : 0);
      m_infl <= fifo_r_en && !fifo_empty;
      if (fifo_r_en && !fifo_empty)
        rd_cnt <= rd_cnt + 1;
      if (m_valid && m_ready) begin
        pops.push_back(m_data);
        pop_total <= pop_total + 1;
      end
    end
  end

  task automatic push_word(input logic [7:0] v);
    mem[wr_ptr[3:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    drain_en = 1'b0;
    m_ready  = 1'b0;
    inf_src  = 1'b0;
    flush_fifo();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    push_word(8'h77);
    #3;
    checks++;
    if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: r_en=%b valid=%b data=%h want 0 0 00",
               fifo_r_en, m_valid, m_data);
    end
`ifdef FIFO_DRAIN_CNT_EN
    checks++;
    if (drain_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0000", drain_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL first_read_early: r_en=%b want 0", fifo_r_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fifo_r_en !== 1'b1) begin
      errors++;
      $display("FAIL first_read_after_edge: r_en=%b want 1", fifo_r_en);
    end
  endtask

  task automatic test_stream();
    logic       exp_ren [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic       exp_vld [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic [7:0] exp_dat [8] = '{0, 0, 10, 20, 30, 40, 0, 0};
    do_reset();
    push_word(8'd10);
    push_word(8'd20);
    push_word(8'd30);
    push_word(8'd40);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        drain_en = 1'b1;
        m_ready  = 1'b1;
      end
      #1;
      checks++;
      if (fifo_r_en !== exp_ren[k] || m_valid !== exp_vld[k]) begin
        errors++;
        $display("FAIL stream_ctl c%0d: r_en=%b valid=%b want %b %b",
                 k, fifo_r_en, m_valid, exp_ren[k], exp_vld[k]);
      end
      if (exp_vld[k]) begin
        checks++;
        if (m_data !== exp_dat[k]) begin
          errors++;
          $display("FAIL stream_data c%0d: got %0d want %0d",
                   k, m_data, exp_dat[k]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4] = '{10, 20, 30, 40};
    int base;
    int pb;
    do_reset();
    push_word(8'd10);
    push_word(8'd20);
    push_word(8'd30);
    push_word(8'd40);
    base = rd_cnt;
    drain_en = 1'b1;
    m_ready  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd10 || fifo_r_en !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold c%0d: valid=%b data=%0d r_en=%b want 1 10 0",
                   k, m_valid, m_data, fifo_r_en);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (rd_cnt - base != 2) begin
      errors++;
      $display("FAIL stall_reads: got %0d want 2", rd_cnt - base);
    end
    pb = pops.size();
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (pops.size() - pb != 4) begin
      errors++;
      $display("FAIL release_count: got %0d want 4", pops.size() - pb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pops[pb+i] !== exp[i]) begin
          errors++;
          $display("FAIL release_order %0d: got %0d want %0d",
                   i, pops[pb+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_drain_stop();
    int pb;
    do_reset();
    push_word(8'd10);
    push_word(8'd20);
    push_word(8'd30);
    pb = pops.size();
    m_ready  = 1'b1;
    drain_en = 1'b1;
    #1;
    checks++;
    if (fifo_r_en !== 1'b1) begin
      errors++;
      $display("FAIL stop_first_read: r_en=%b want 1", fifo_r_en);
    end
    @(negedge clk);
    drain_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (fifo_r_en !== 1'b0) begin
        errors++;
        $display("FAIL stop_no_read c%0d: r_en=%b want 0", k, fifo_r_en);
      end
      @(negedge clk);
    end
    checks++;
    if (pops.size() - pb != 1 || pops[pb] !== 8'd10) begin
      errors++;
      $display("FAIL stop_delivered: count=%0d want 1 of value 10",
               pops.size() - pb);
    end
    checks++;
    if (wr_ptr - rd_ptr != 2 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_remaining: left=%0d valid=%b want 2 0",
               wr_ptr - rd_ptr, m_valid);
    end
  endtask

  task automatic test_empty();
    do_reset();
    drain_en = 1'b1;
    m_ready  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++;
      if (fifo_r_en !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle c%0d: r_en=%b valid=%b want 0 0",
                 k, fifo_r_en, m_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int pb;
    do_reset();
    push_word(8'd10);
    push_word(8'd20);
    push_word(8'd30);
    push_word(8'd40);
    drain_en = 1'b1;
    m_ready  = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_occ != 2) begin
      errors++;
      $display("FAIL mid_prefill: valid=%b occ=%0d want 1 2", m_valid, m_occ);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: valid=%b data=%h r_en=%b want 0 00 0",
               m_valid, m_data, fifo_r_en);
    end
    @(negedge clk);
    flush_fifo();
    pb = pops.size();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (pops.size() != pb || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: pops=%0d valid=%b want 0 0",
               pops.size() - pb, m_valid);
    end
  endtask

`ifdef FIFO_DRAIN_CNT_EN
  task automatic test_cnt_wrap();
    int base;
    do_reset();
    base     = pop_total;
    inf_src  = 1'b1;
    m_ready  = 1'b1;
    drain_en = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (pop_total - base >= 65535) break;
    end
    m_ready = 1'b0;
    #1;
    checks++;
    if (pop_total - base != 65535 || drain_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_preset: pops=%0d cnt=%h want 65535 ffff",
               pop_total - base, drain_cnt);
    end
    @(negedge clk);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    m_ready = 1'b0;
    #1;
    checks++;
    if (drain_cnt !== 16'd3) begin
      errors++;
      $display("FAIL cnt_wrap: got %h want 0003", drain_cnt);
    end
    drain_en = 1'b0;
    inf_src  = 1'b0;
  endtask
`endif

  task automatic test_no_overflow();
    checks++;
    if (ovf_cnt != 0) begin
      errors++;
      $display("FAIL buffer_overflow: captures into full buffer=%0d want 0",
               ovf_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain_stop();
    test_empty();
    test_reset_mid();
`ifdef FIFO_DRAIN_CNT_EN
    test_cnt_wrap();
`endif
    test_no_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, FIFO and stream word width in bits.
REQ-002 Parameter BUF_DEPTH, default 2, output buffer entries (fixed at 2; other values unsupported).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 drain_en  input  1  1 = issue FIFO reads; 0 = issue no new reads, in-flight read still completes.
REQ-006 fifo_empty  input  1  empty flag from FIFO read side.
REQ-007 fifo_data  input  DATA_W  FIFO data_out, registered, valid the cycle after an accepted read.
REQ-008 fifo_r_en  output  1  FIFO read enable.
REQ-009 m_valid  output  1  downstream word valid.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 m_data  output  DATA_W  downstream word.
REQ-012 drain_cnt  output  16  words delivered downstream; present only with FIFO_DRAIN_CNT_EN.

Function
REQ-013 Read accepted = fifo_r_en && !fifo_empty; flag inflight SHALL be set the next cycle and cleared the cycle after.
REQ-014 Pop = m_valid && m_ready; exactly one word leaves per pop, oldest first.
REQ-015 Buffer occupancy occ SHALL track states EMPTY(0), ONE(1), TWO(2): +1 on inflight capture, -1 on pop, unchanged when both occur in one cycle.
REQ-016 fifo_r_en = drain_en && !fifo_empty && (occ + inflight - pop) < 2 (combinational, pop-aware); sustains 1 word/cycle.
REQ-017 fifo_r_en SHALL never be asserted while fifo_empty=1.
REQ-018 Latency: r_en accepted in cycle N -> fifo_data sampled at end of N+1 -> m_valid=1 in N+2 when occ was 0.
REQ-019 m_valid = (occ != 0); m_data = head entry; m_data SHALL stay stable while m_valid && !m_ready.
REQ-020 Capture with occ=2 and no pop SHALL be impossible by REQ-016; the bench SHALL flag it as an error.
REQ-021 drain_en deassert mid-stream: the in-flight word is still captured and buffered words still drain.
REQ-022 Simultaneous capture and pop at occ=1: head pops, new word becomes head the next cycle, m_valid stays 1.
REQ-023 m_ready held low: at most 2 words buffered; fifo_r_en SHALL stay 0 until a pop.

Reset
REQ-024 rst_n=0 SHALL immediately clear occ, inflight, m_valid, m_data(0), drain_cnt(0) and force fifo_r_en=0.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight words; a read issued in the cycle before reset is lost.
REQ-026 First read SHALL be issued no earlier than the first clk edge after rst_n rises.

Configuration
REQ-027 Macro FIFO_DRAIN_CNT_EN defined: drain_cnt increments by 1 per pop, wraps 0xFFFF->0x0000, reset 0.
REQ-028 Macro undefined: drain_cnt port and counter are absent; all other behaviour identical.

Verification
REQ-029 FIFO preloaded 10,20,30,40, drain_en=1, m_ready=1 -> m_data 10,20,30,40 on 4 consecutive cycles, first at 2 cycles after first r_en.
REQ-030 Same preload, m_ready=0 -> exactly 2 reads issued, m_valid=1 holding 10; m_ready=1 -> 10,20,30,40 in order, no loss or duplicate.
REQ-031 Preload 10,20,30; drop drain_en the cycle after first r_en -> 10 delivered, fifo_r_en stays 0, 20 and 30 remain in FIFO.
REQ-032 fifo_empty=1 throughout with drain_en=1 -> fifo_r_en=0, m_valid=0 for 20 cycles.
REQ-033 Assert rst_n=0 mid-stream with occ=2 -> m_valid=0, m_data=0, fifo_r_en=0 immediately, without a clk edge.
REQ-034 With FIFO_DRAIN_CNT_EN, counter preset by 65535 pops then 4 more words -> drain_cnt reads 3 after wrap.
